// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: data/address widths, register count and the
// write-port arbiter FSM encoding.
package rv32_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

    // One-hot register mask; x0 is hardwired zero so it never produces a bit.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic en, input reg_addr_t addr);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (en && (addr != '0)) begin
            mask[addr] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of writeback, MDU, decode and reg_file write-port signals around the
// register-file write arbiter.
interface rf_write_arbiter_if #(
    parameter int unsigned XLEN = rv32_pkg::XLEN
);
    import rv32_pkg::*;

    logic                WB_VALID;
    reg_addr_t           WB_ADDRESS;
    logic [XLEN-1:0]     WB_DATA;
    logic                MDU_VALID;
    reg_addr_t           MDU_ADDRESS;
    logic [XLEN-1:0]     MDU_DATA;
    logic                MDU_READY;
    logic                ISSUE_VALID;
    reg_addr_t           ISSUE_ADDRESS;
    reg_addr_t           RS1_ADDRESS;
    reg_addr_t           RS2_ADDRESS;
    reg_addr_t           RD_ADDRESS;
    logic                HAZARD;
    logic                WRITE_ENABLE;
    reg_addr_t           WRITE_ADDRESS;
    logic [XLEN-1:0]     WRITE_DATA;
    logic [NUM_REGS-1:0] BUSY;

    modport master (
        output WB_VALID, WB_ADDRESS, WB_DATA,
        output MDU_VALID, MDU_ADDRESS, MDU_DATA,
        output ISSUE_VALID, ISSUE_ADDRESS,
        output RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS,
        input  MDU_READY, HAZARD,
        input  WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, BUSY
    );

    modport slave (
        input  WB_VALID, WB_ADDRESS, WB_DATA,
        input  MDU_VALID, MDU_ADDRESS, MDU_DATA,
        input  ISSUE_VALID, ISSUE_ADDRESS,
        input  RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS,
        output MDU_READY, HAZARD,
        output WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, BUSY
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy bit per architectural register for outstanding MDU destinations, with a
// three-port lookup for the instruction sitting in decode.
module rf_scoreboard
    import rv32_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                set_en,
    input  reg_addr_t           set_addr,
    input  logic                clr_en,
    input  reg_addr_t           clr_addr,
    input  reg_addr_t           rs1_addr,
    input  reg_addr_t           rs2_addr,
    input  reg_addr_t           rd_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic                hit_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask_c;
    logic [NUM_REGS-1:0] clr_mask_c;

    // Clear is applied before set so a same-edge issue to the retiring register stays busy.
    always_comb begin
        set_mask_c = reg_mask(set_en, set_addr);
        clr_mask_c = reg_mask(clr_en, clr_addr);
        busy_d     = (busy_q & ~clr_mask_c) | set_mask_c;
        busy_d[0]  = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // busy_q[0] is never set, so x0 operands cannot hazard.
    always_comb begin
        hit_c = busy_q[rs1_addr] | busy_q[rs2_addr] | busy_q[rd_addr];
    end

    assign busy = busy_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared between writeback (fixed priority) and
// the MDU, with starvation-driven decode bubbles and an MDU busy scoreboard.
module rf_write_arbiter #(
    parameter int unsigned XLEN         = rv32_pkg::XLEN,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    rf_write_arbiter_if.slave bus
);
    import rv32_pkg::*;

    localparam int unsigned      CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    logic wb_live_c;
    logic mdu_ready_c;
    logic mdu_write_c;
    logic mdu_blocked_c;
    logic force_c;
    logic sb_hit_c;

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;

    logic            we_q;
    logic            from_mdu_q;
    reg_addr_t       waddr_q;
    logic [XLEN-1:0] wdata_q;

    // Port arbitration: a WB to x0 is dropped and leaves the port to the MDU.
    always_comb begin
        wb_live_c     = bus.WB_VALID & (bus.WB_ADDRESS != '0);
        mdu_ready_c   = bus.MDU_VALID & ~wb_live_c;
        mdu_write_c   = mdu_ready_c & (bus.MDU_ADDRESS != '0);
        mdu_blocked_c = bus.MDU_VALID & wb_live_c;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Starvation tracking; the counter saturates rather than wrapping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        unique case (state_q)
            ST_IDLE: begin
                if (mdu_blocked_c) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (!mdu_blocked_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c >= CNT_LIMIT) begin
                        state_d = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                if (!mdu_blocked_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        force_c = 1'b0;
        if (state_q == ST_FORCE) begin
            force_c = 1'b1;
        end
    end

    // Registered write port; address/data hold their last value when idle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            we_q       <= 1'b0;
            from_mdu_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            we_q       <= wb_live_c | mdu_write_c;
            from_mdu_q <= mdu_write_c;
            if (wb_live_c) begin
                waddr_q <= bus.WB_ADDRESS;
                wdata_q <= bus.WB_DATA;
            end else if (mdu_write_c) begin
                waddr_q <= bus.MDU_ADDRESS;
                wdata_q <= bus.MDU_DATA;
            end
        end
    end

    // MDU destinations retire on the edge that commits them into reg_file.
    rf_scoreboard u_scoreboard (
        .CLK      (CLK),
        .RESET    (RESET),
        .set_en   (bus.ISSUE_VALID),
        .set_addr (bus.ISSUE_ADDRESS),
        .clr_en   (we_q & from_mdu_q),
        .clr_addr (waddr_q),
        .rs1_addr (bus.RS1_ADDRESS),
        .rs2_addr (bus.RS2_ADDRESS),
        .rd_addr  (bus.RD_ADDRESS),
        .busy     (bus.BUSY),
        .hit_c    (sb_hit_c)
    );

    assign bus.MDU_READY     = mdu_ready_c;
    assign bus.HAZARD        = sb_hit_c | force_c;
    assign bus.WRITE_ENABLE  = we_q;
    assign bus.WRITE_ADDRESS = waddr_q;
    assign bus.WRITE_DATA    = wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized bench for rf_write_arbiter against a cycle-level
// model of the shared write port, busy set and starvation count.
module tb_rf_write_arbiter;

    localparam int unsigned LIMIT = 4;

    logic CLK;
    logic RESET;

    rf_write_arbiter_if #(.XLEN(32)) bus ();

    rf_write_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Reference: what reg_file sees on its port, which registers await the MDU,
    // and how many consecutive cycles the MDU has been refused.
    logic        m_we;
    logic        m_mdu;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] busy_m;
    int unsigned starve;
    logic        last_ready;
    logic        last_reset;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.WB_VALID      = 1'b0;
        bus.WB_ADDRESS    = 5'd0;
        bus.WB_DATA       = 32'd0;
        bus.MDU_VALID     = 1'b0;
        bus.MDU_ADDRESS   = 5'd0;
        bus.MDU_DATA      = 32'd0;
        bus.ISSUE_VALID   = 1'b0;
        bus.ISSUE_ADDRESS = 5'd0;
        bus.RS1_ADDRESS   = 5'd0;
        bus.RS2_ADDRESS   = 5'd0;
        bus.RD_ADDRESS    = 5'd0;
    endtask

    // Check all outputs mid-cycle, then advance the model across the clock edge.
    task automatic cycle();
        logic live;
        logic exp_ready;
        logic exp_haz;
        @(negedge CLK);
        #1;
        live      = bus.WB_VALID && (bus.WB_ADDRESS != 5'd0);
        exp_ready = bus.MDU_VALID && !live;
        exp_haz   = busy_m[bus.RS1_ADDRESS] | busy_m[bus.RS2_ADDRESS] |
                    busy_m[bus.RD_ADDRESS] | (starve >= LIMIT);
        check("mdu_ready", 32'(bus.MDU_READY), 32'(exp_ready));
        check("hazard", 32'(bus.HAZARD), 32'(exp_haz));
        check("write_enable", 32'(bus.WRITE_ENABLE), 32'(m_we));
        check("write_address", 32'(bus.WRITE_ADDRESS), 32'(m_addr));
        check("write_data", bus.WRITE_DATA, m_data);
        check("busy", bus.BUSY, busy_m);
        @(posedge CLK);
        last_ready = exp_ready;
        last_reset = RESET;
        if (RESET) begin
            m_we   = 1'b0;
            m_mdu  = 1'b0;
            m_addr = 5'd0;
            m_data = 32'd0;
            busy_m = 32'd0;
            starve = 0;
        end else begin
            if (m_we && m_mdu) busy_m[m_addr] = 1'b0;
            if (bus.ISSUE_VALID && bus.ISSUE_ADDRESS != 5'd0) busy_m[bus.ISSUE_ADDRESS] = 1'b1;
            starve = (bus.MDU_VALID && live) ? starve + 1 : 0;
            if (live) begin
                m_we = 1'b1; m_mdu = 1'b0; m_addr = bus.WB_ADDRESS; m_data = bus.WB_DATA;
            end else if (bus.MDU_VALID && bus.MDU_ADDRESS != 5'd0) begin
                m_we = 1'b1; m_mdu = 1'b1; m_addr = bus.MDU_ADDRESS; m_data = bus.MDU_DATA;
            end else begin
                m_we = 1'b0; m_mdu = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        m_we = 1'b0; m_mdu = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        busy_m = 32'd0; starve = 0; last_ready = 1'b0; last_reset = 1'b1;
        RESET = 1'b1;
        idle_inputs();
        @(posedge CLK);
        #1;
        cycle();
        cycle();
        check("rst_we", 32'(bus.WRITE_ENABLE), 32'd0);
        check("rst_addr", 32'(bus.WRITE_ADDRESS), 32'd0);
        check("rst_data", bus.WRITE_DATA, 32'd0);
        check("rst_busy", bus.BUSY, 32'd0);
        check("rst_hazard", 32'(bus.HAZARD), 32'd0);
        RESET = 1'b0;

        // Plain writeback
        bus.WB_VALID = 1'b1; bus.WB_ADDRESS = 5'd5; bus.WB_DATA = 32'hDEADBEEF;
        cycle();
        check("wb_we", 32'(bus.WRITE_ENABLE), 32'd1);
        check("wb_addr", 32'(bus.WRITE_ADDRESS), 32'd5);
        check("wb_data", bus.WRITE_DATA, 32'hDEADBEEF);
        idle_inputs();

        // MDU alone, then MDU alongside a WB to x0
        bus.MDU_VALID = 1'b1; bus.MDU_ADDRESS = 5'd7; bus.MDU_DATA = 32'h0000_7777;
        #1 check("mdu_ready_idle", 32'(bus.MDU_READY), 32'd1);
        cycle();
        check("mdu_addr", 32'(bus.WRITE_ADDRESS), 32'd7);
        check("mdu_data", bus.WRITE_DATA, 32'h0000_7777);
        bus.MDU_ADDRESS = 5'd8; bus.MDU_DATA = 32'h0000_8888;
        bus.WB_VALID = 1'b1; bus.WB_ADDRESS = 5'd0; bus.WB_DATA = 32'h0BAD_0BAD;
        #1 check("mdu_ready_wb_x0", 32'(bus.MDU_READY), 32'd1);
        cycle();
        check("mdu_over_x0_addr", 32'(bus.WRITE_ADDRESS), 32'd8);
        check("mdu_over_x0_data", bus.WRITE_DATA, 32'h0000_8888);
        idle_inputs();

        // Scoreboard RAW on x9 until the MDU write has retired
        bus.ISSUE_VALID = 1'b1; bus.ISSUE_ADDRESS = 5'd9;
        cycle();
        bus.ISSUE_VALID = 1'b0; bus.RS2_ADDRESS = 5'd9;
        #1 check("x9_hazard", 32'(bus.HAZARD), 32'd1);
        check("x9_busy", bus.BUSY, 32'h0000_0200);
        cycle();
        cycle();
        bus.MDU_VALID = 1'b1; bus.MDU_ADDRESS = 5'd9; bus.MDU_DATA = 32'h0000_0099;
        cycle();
        bus.MDU_VALID = 1'b0;
        #1 check("x9_hazard_on_port", 32'(bus.HAZARD), 32'd1);
        cycle();
        check("x9_hazard_cleared", 32'(bus.HAZARD), 32'd0);
        check("x9_busy_cleared", bus.BUSY, 32'd0);
        bus.RS2_ADDRESS = 5'd0;
        bus.ISSUE_VALID = 1'b1; bus.ISSUE_ADDRESS = 5'd0;
        cycle();
        bus.ISSUE_VALID = 1'b0;
        check("issue_x0_busy", bus.BUSY, 32'd0);

        // Same-edge set and clear of x3
        bus.ISSUE_VALID = 1'b1; bus.ISSUE_ADDRESS = 5'd3;
        cycle();
        bus.ISSUE_VALID = 1'b0;
        bus.MDU_VALID = 1'b1; bus.MDU_ADDRESS = 5'd3; bus.MDU_DATA = 32'h0000_0033;
        cycle();
        bus.MDU_VALID = 1'b0;
        bus.ISSUE_VALID = 1'b1; bus.ISSUE_ADDRESS = 5'd3;
        cycle();
        bus.ISSUE_VALID = 1'b0;
        check("x3_set_wins", bus.BUSY, 32'h0000_0008);
        bus.MDU_VALID = 1'b1;
        cycle();
        bus.MDU_VALID = 1'b0;
        cycle();
        check("x3_cleared", bus.BUSY, 32'd0);

        // Starvation under continuous WB traffic
        bus.MDU_VALID = 1'b1; bus.MDU_ADDRESS = 5'd12; bus.MDU_DATA = 32'h0000_000C;
        bus.WB_VALID = 1'b1;
        bus.WB_ADDRESS = 5'($urandom_range(31, 1)); bus.WB_DATA = $urandom; cycle();
        bus.WB_ADDRESS = 5'($urandom_range(31, 1)); bus.WB_DATA = $urandom; cycle();
        bus.WB_ADDRESS = 5'($urandom_range(31, 1)); bus.WB_DATA = $urandom; cycle();
        check("starve3_no_force", 32'(bus.HAZARD), 32'd0);
        bus.WB_ADDRESS = 5'($urandom_range(31, 1)); bus.WB_DATA = $urandom; cycle();
        check("starve4_force", 32'(bus.HAZARD), 32'd1);
        bus.WB_ADDRESS = 5'($urandom_range(31, 1)); bus.WB_DATA = $urandom; cycle();
        bus.WB_VALID = 1'b0;
        #1 check("force_ready", 32'(bus.MDU_READY), 32'd1);
        check("force_hazard_held", 32'(bus.HAZARD), 32'd1);
        cycle();
        bus.MDU_VALID = 1'b0;
        check("starved_addr", 32'(bus.WRITE_ADDRESS), 32'd12);
        check("starved_data", bus.WRITE_DATA, 32'h0000_000C);
        check("force_released", 32'(bus.HAZARD), 32'd0);

        // Reset while waiting: no write, then fresh grant
        bus.MDU_VALID = 1'b1; bus.MDU_ADDRESS = 5'd13; bus.MDU_DATA = 32'h0000_000D;
        bus.WB_VALID = 1'b1; bus.WB_ADDRESS = 5'd4; bus.WB_DATA = 32'h4444_4444;
        cycle();
        cycle();
        bus.WB_VALID = 1'b0;
        RESET = 1'b1;
        cycle();
        check("rst_wait_no_write", 32'(bus.WRITE_ENABLE), 32'd0);
        check("rst_wait_addr", 32'(bus.WRITE_ADDRESS), 32'd0);
        check("rst_wait_hazard", 32'(bus.HAZARD), 32'd0);
        RESET = 1'b0;
        cycle();
        check("post_rst_we", 32'(bus.WRITE_ENABLE), 32'd1);
        check("post_rst_addr", 32'(bus.WRITE_ADDRESS), 32'd13);
        bus.MDU_VALID = 1'b0;
        cycle();

        // Randomized traffic; MDU holds its result until accepted
        for (int i = 0; i < 600; i++) begin
            RESET = ($urandom_range(99) == 0);
            bus.WB_VALID   = ($urandom_range(9) < 7);
            bus.WB_ADDRESS = 5'($urandom_range(31));
            bus.WB_DATA    = $urandom;
            if (!bus.MDU_VALID || (last_ready && !last_reset)) begin
                bus.MDU_VALID   = 1'($urandom_range(1));
                bus.MDU_ADDRESS = 5'($urandom_range(31));
                bus.MDU_DATA    = $urandom;
            end
            bus.ISSUE_VALID   = ($urandom_range(3) == 0);
            bus.ISSUE_ADDRESS = 5'($urandom_range(31));
            bus.RS1_ADDRESS   = 5'($urandom_range(15));
            bus.RS2_ADDRESS   = 5'($urandom_range(15));
            bus.RD_ADDRESS    = 5'($urandom_range(15));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the pipeline writeback stage and the multi-cycle MUL/DIV unit (MDU) of the RV32IM core. It keeps a per-register busy scoreboard for MDU destinations and raises HAZARD to stall decode on RAW/WAW conflicts. It also forces pipeline bubbles when the MDU has been starved of the port. It sits between WB/MDU and `reg_file`, and drives that block's WRITE_ENABLE, WRITE_ADDRESS and WRITE_DATA.

## Interface
Parameters:
- XLEN, 32, data width
- STARVE_LIMIT, 4, cycles an MDU result may wait before bubbles are forced (≥1)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high
- WB_VALID  in  1  writeback stage has a result
- WB_ADDRESS  in  5  writeback destination
- WB_DATA  in  XLEN  writeback value
- MDU_VALID  in  1  MDU result pending; held stable until accepted
- MDU_ADDRESS  in  5  MDU destination
- MDU_DATA  in  XLEN  MDU value
- MDU_READY  out  1  MDU result accepted this cycle (combinational)
- ISSUE_VALID  in  1  MDU op dispatched from decode this cycle
- ISSUE_ADDRESS  in  5  destination of dispatched MDU op
- RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS  in  5 each  operands/destination of instruction in decode
- HAZARD  out  1  stall decode (combinational)
- WRITE_ENABLE  out  1  to reg_file (registered)
- WRITE_ADDRESS  out  5  to reg_file (registered)
- WRITE_DATA  out  XLEN  to reg_file (registered)
- BUSY  out  32  scoreboard vector; bit 0 always 0

## Operation
- A WB request is live when WB_VALID=1 and WB_ADDRESS≠0. WB has fixed priority and is never stalled. A WB with address 0 is dropped and leaves the port free.
- MDU_READY = MDU_VALID & !(WB live). An MDU result with MDU_ADDRESS=0 is accepted and discarded (no write).
- Grant winner is registered into the WRITE_* outputs. WRITE_ENABLE=0 when there is no winner; WRITE_ADDRESS and WRITE_DATA then hold their last values.
- Scoreboard:
  - ISSUE_VALID with ISSUE_ADDRESS≠0 sets BUSY[ISSUE_ADDRESS].
  - A bit clears at the edge ending the cycle in which WRITE_ENABLE=1 with that WRITE_ADDRESS from an MDU grant.
  - If a set and a clear hit the same bit on the same edge, the set wins.
- HAZARD = BUSY[RS1_ADDRESS] | BUSY[RS2_ADDRESS] | BUSY[RD_ADDRESS] | (state==FORCE). Index 0 never hazards.
- FSM, 2-bit state, one register:
  - IDLE: MDU_VALID & !MDU_READY → WAIT, wait counter=1.
  - WAIT: MDU_READY → IDLE. Otherwise the counter increments; at counter==STARVE_LIMIT → FORCE.
  - FORCE: HAZARD=1 so bubbles drain WB. MDU_READY → IDLE.
- The wait counter is $clog2(STARVE_LIMIT+1) bits and saturates; it never wraps.

## Timing
- Grant to reg_file write: the winner appears on WRITE_* in the next cycle. reg_file captures it at the end of that cycle.
- The scoreboard clears on that same edge, so decode reads the new value the following cycle (reg_file read path is combinational).
- Worst-case MDU wait with continuous WB traffic: STARVE_LIMIT cycles plus pipeline drain depth.
- Reset values: WRITE_ENABLE=0, WRITE_ADDRESS=0, WRITE_DATA=0, BUSY=0, state=IDLE, counter=0. RESET dominates all other inputs on the same edge.
- Reset mid-operation: a pending MDU result is not written. The MDU must hold MDU_VALID, and it is arbitrated afresh after reset.
- MDU_READY and HAZARD have no input-to-output register; no other combinational paths exist.

## Structure
- Shared package `rv32_pkg`: XLEN, REG_ADDR_W=5, NUM_REGS=32, and the FSM state encoding (IDLE=0, WAIT=1, FORCE=2).
- One natural sub-module: `rf_scoreboard`, which holds the 32-bit set/clear vector and does the three-port hazard lookup.
- Arbiter, FSM and output register live in the top module.

## Test plan
- After reset, WB_VALID=1, WB_ADDRESS=5, WB_DATA=0xDEADBEEF → next cycle WRITE_ENABLE=1, WRITE_ADDRESS=5, WRITE_DATA=0xDEADBEEF. All outputs were 0 during reset.
- MDU_VALID=1 with address 7 and WB idle → MDU_READY=1 in the same cycle; WRITE_* shows 7 next cycle. WB_ADDRESS=0 together with MDU_VALID → MDU still granted.
- ISSUE_VALID with ISSUE_ADDRESS=9, then RS2_ADDRESS=9 → HAZARD=1 until the cycle after the MDU write of x9, then HAZARD=0. ISSUE_ADDRESS=0 → BUSY stays 0.
- WB live every cycle with MDU_VALID held and STARVE_LIMIT=4 → FORCE is entered after 4 cycles and HAZARD=1. The first WB_VALID=0 cycle grants the MDU, and the state returns to IDLE.
- A same-edge ISSUE of x3 and MDU write clearing x3 → BUSY[3] remains 1.
- RESET asserted in WAIT with MDU_VALID held → state=IDLE and counter=0, no spurious write, and the MDU is granted after reset.
